instr_encoder: RTL and testbench

// - Encoder end of the control decode path: turns field-level instruction requests (op, rd, rs1, rs2, imm)

---
 rtl/instr_encoder.sv | 114 +++++++++++
 tb/tb_instr_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Field-level RV32I subset encoder (add/sub/and/or/lw/sw/beq) that writes each
// encoded word to instruction memory at sequential word addresses.
module instr_encoder #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [12:0]       imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err,
   output logic [1:0]        dbg_state
);

   // Handshake: a request transfers on a rising edge where in_valid and
   // in_ready are both high; in_ready never depends on in_valid.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_BEQ = 3'b110;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

   state_t          state, state_nxt;
   logic            accept;
   logic            illegal;
   logic [31:0]     enc_word;
   logic [ADDR_W:0] count_inc;

   assign in_ready  = (state == IDLE) && !clr && !rst;
   assign accept    = in_valid && in_ready;
   // Odd branch offsets cannot be encoded since imm[0] is implicit zero.
   assign illegal   = (op == 3'b111) || ((op == OP_BEQ) && imm[0]);
   assign count_inc = count + ONE_C;
   assign full      = (state == FULL);
   assign dbg_state = state;

   always_comb begin
      enc_word = 32'd0;
      case (op)
         OP_ADD: enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
         OP_SUB: enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
         OP_AND: enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
         OP_OR:  enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
         OP_LW:  enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
         OP_SW:  enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
         OP_BEQ: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
         default: enc_word = 32'd0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (accept && !illegal) state_nxt = WRITE;
         end
         WRITE: begin
            mem_we    = !clr;
            state_nxt = (count_inc == DEPTH_C) ? FULL : IDLE;
         end
         FULL:    state_nxt = FULL;
         default: state_nxt = IDLE;
      endcase
      if (clr) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_wdata <= 32'd0;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (clr) begin
            count <= '0;
            err   <= 1'b0;
         end else begin
            if (accept && illegal) err <= 1'b1;
            if (accept && !illegal) begin
               mem_addr  <= count[ADDR_W-1:0];
               mem_wdata <= enc_word;
            end
            if (state == WRITE) count <= count_inc;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (DEPTH=4): directed field vectors, illegal requests,
// full/clr/rst corner cases and a few random R-type/LW requests.
module tb_instr_encoder;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clr = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        op = 3'd0;
   logic [4:0]        rd = 5'd0;
   logic [4:0]        rs1 = 5'd0;
   logic [4:0]        rs2 = 5'd0;
   logic [12:0]       imm = 13'd0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;
   logic [1:0]        dbg_state;

   logic [ADDR_W+31:0] exp_q[$];
   int                 n_cmp = 0;
   int                 n_err = 0;
   int                 exp_count = 0;

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .full(full), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference encoding written from the RV32I field layout.
   function automatic logic [31:0] model_enc(input logic [2:0] o, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [12:0] im);
      case (o)
         3'd0: return {7'h00, s2, s1, 3'h0, d, 7'h33};
         3'd1: return {7'h20, s2, s1, 3'h0, d, 7'h33};
         3'd2: return {7'h00, s2, s1, 3'h7, d, 7'h33};
         3'd3: return {7'h00, s2, s1, 3'h6, d, 7'h33};
         3'd4: return {im[11:0], s1, 3'h2, d, 7'h03};
         default: return 32'd0;
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [12:0] im,
                       input bit push, input logic [31:0] word);
      int n = 0;
      op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready) begin
         check("ready_timeout", in_ready, 1'b1);
      end else if (push) begin
         exp_q.push_back({ADDR_W'(exp_count), word});
         exp_count++;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_count = 0;
   endtask

   always begin
      @(negedge clk); #2;
      if (mem_we) begin
         check("we_ready_low", in_ready, 1'b0);
         if (exp_q.size() == 0) begin
            check("unexpected_we", mem_we, 1'b0);
         end else begin
            logic [ADDR_W+31:0] e;
            e = exp_q.pop_front();
            check("waddr", mem_addr, e[ADDR_W+31:32]);
            check("wdata", mem_wdata, e[31:0]);
         end
      end
   end

   initial begin
      #1;
      check("rst_ready", in_ready, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 1'b0);
      check("rst_err", err, 1'b0);
      idle(2);
      rst = 1'b0;
      idle(1);

      send(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1, 32'h002081B3);
      idle(1);
      check("count_after_add", count, 1);

      send(3'd1, 5'd5, 5'd6, 5'd7, 13'd0, 1, 32'h407302B3);
      send(3'd4, 5'd4, 5'd2, 5'd0, 13'd8, 1, 32'h00812203);
      idle(1);
      check("count_after_lw", count, 3);
      do_clr();
      check("count_after_clr", count, 0);

      send(3'd5, 5'd31, 5'd2, 5'd5, 13'd12, 1, 32'h00512623);
      send(3'd6, 5'd31, 5'd1, 5'd2, 13'h1FF8, 1, 32'hFE208CE3);
      idle(1);
      send(3'd7, 5'd1, 5'd1, 5'd1, 13'd0, 0, 32'd0);
      check("err_after_op7", err, 1'b1);
      send(3'd6, 5'd0, 5'd1, 5'd2, 13'h0005, 0, 32'd0);
      check("count_after_illegal", count, 2);
      send(3'd2, 5'd1, 5'd2, 5'd3, 13'd0, 1, 32'h003170B3);
      send(3'd3, 5'd8, 5'd9, 5'd10, 13'd0, 1, 32'h00A4E433);
      idle(1);
      check("err_sticky", err, 1'b1);
      check("full_set", full, 1'b1);
      check("full_count", count, DEPTH);
      check("full_ready", in_ready, 1'b0);
      op = 3'd0; in_valid = 1'b1;
      idle(8);
      in_valid = 1'b0;
      check("full_hold_count", count, DEPTH);

      do_clr();
      check("clr_full", full, 1'b0);
      check("clr_err", err, 1'b0);
      check("clr_count", count, 0);
      send(3'd0, 5'd1, 5'd2, 5'd3, 13'd0, 1, 32'h003100B3);
      idle(1);

      // Clear during the WRITE cycle drops the pending word.
      send(3'd1, 5'd2, 5'd3, 5'd4, 13'd0, 0, 32'd0);
      do_clr();
      check("clr_in_write_count", count, 0);

      for (int i = 0; i < 3; i++) begin
         logic [2:0]  ro;
         logic [4:0]  rd_r, s1_r, s2_r;
         logic [12:0] im_r;
         ro   = 3'($urandom_range(0, 4));
         rd_r = 5'($urandom_range(0, 31));
         s1_r = 5'($urandom_range(0, 31));
         s2_r = 5'($urandom_range(0, 31));
         im_r = 13'($urandom_range(0, 8191));
         send(ro, rd_r, s1_r, s2_r, im_r, 1, model_enc(ro, rd_r, s1_r, s2_r, im_r));
      end
      idle(1);
      check("count_after_rand", count, 3);

      send(3'd7, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'd0);
      send(3'd0, 5'd9, 5'd9, 5'd9, 13'd0, 0, 32'd0);
      rst = 1'b1;
      #1;
      check("midrst_we", mem_we, 1'b0);
      check("midrst_ready", in_ready, 1'b0);
      check("midrst_addr", mem_addr, 0);
      check("midrst_wdata", mem_wdata, 0);
      check("midrst_count", count, 0);
      check("midrst_full", full, 1'b0);
      check("midrst_err", err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      idle(1);
      send(3'd4, 5'd7, 5'd8, 5'd0, 13'h0FFC, 1, 32'hFFC42383);
      idle(2);
      check("count_final", count, 1);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
